dct_transpose_buf: RTL and testbench

//   Row-to-column transpose buffer between the row-pass fbindct_8bit and the column-pass 1-D binDCT.

---
 rtl/dct_pkg.sv | 23 ++
 rtl/dct_tp_bank.sv | 51 +++++
 rtl/dct_transpose_buf.sv | 147 ++++++++++++++
 tb/tb_dct_transpose_buf.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Types and constants shared by the 8x8 binDCT datapath (row pass, transpose, column pass).
package dct_pkg;

    localparam int N           = 8;
    localparam int IN_WIDTH    = 8;
    localparam int INT_BITS    = 4;
    localparam int FRAC_BITS   = 6;
    localparam int INTER_WIDTH = IN_WIDTH + INT_BITS + FRAC_BITS;

    typedef logic signed [INTER_WIDTH-1:0] coef_t;
    typedef coef_t [N-1:0] row_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    function automatic logic [2:0] idx_inc(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 coefficient bank: whole-row write port, combinational whole-column read port.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = INTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [2:0]            wr_row,
    input  logic [DATA_WIDTH-1:0] wr_data [N-1:0],
    input  logic [2:0]            rd_col,
    output logic [DATA_WIDTH-1:0] rd_data [N-1:0]
);

    logic [DATA_WIDTH-1:0] mem_q [N-1:0][N-1:0];
    logic [DATA_WIDTH-1:0] mem_d [N-1:0][N-1:0];

    // Row write: only the addressed row changes.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int c = 0; c < N; c++) begin
                mem_d[wr_row][c] = wr_data[c];
            end
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Column read: element r of the column comes from row r.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            rd_data[r] = mem_q[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong row-to-column transpose buffer: rows in at one per cycle, columns out over valid/ready.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int DATA_WIDTH = INTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] row_in [7:0],
    input  logic                  valid_in,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] col_out [7:0],
    output logic [2:0]            col_idx,
    output logic                  last_out,
    output logic                  valid_out,
    input  logic                  out_ready,
    output logic                  overflow
);

    bank_state_e           state_q [0:1];
    bank_state_e           state_d [0:1];
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [2:0]            wr_row_q, wr_row_d;
    logic [2:0]            rd_col_q, rd_col_d;
    logic [DATA_WIDTH-1:0] col_out_q [7:0];
    logic [DATA_WIDTH-1:0] col_out_d [7:0];
    logic [2:0]            col_idx_q, col_idx_d;
    logic                  valid_out_q, valid_out_d;
    logic                  overflow_q, overflow_d;

    logic                  in_ready_s;
    logic                  wr_en_s;
    logic                  load_s;
    logic                  we0_s, we1_s;
    logic [DATA_WIDTH-1:0] rd0_s  [7:0];
    logic [DATA_WIDTH-1:0] rd1_s  [7:0];
    logic [DATA_WIDTH-1:0] rdsel_s [7:0];

    assign in_ready_s = (state_q[wr_bank_q] != FULL);
    assign wr_en_s    = valid_in && in_ready_s;
    assign load_s     = (state_q[rd_bank_q] == FULL) && (!valid_out_q || out_ready);
    assign we0_s      = wr_en_s && (wr_bank_q == 1'b0);
    assign we1_s      = wr_en_s && (wr_bank_q == 1'b1);

    dct_tp_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (we0_s),
        .wr_row  (wr_row_q),
        .wr_data (row_in),
        .rd_col  (rd_col_q),
        .rd_data (rd0_s)
    );

    dct_tp_bank #(.DATA_WIDTH(DATA_WIDTH)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (we1_s),
        .wr_row  (wr_row_q),
        .wr_data (row_in),
        .rd_col  (rd_col_q),
        .rd_data (rd1_s)
    );

    // Column selected from the bank currently being drained.
    always_comb begin
        for (int r = 0; r < 8; r++) begin
            rdsel_s[r] = rd_bank_q ? rd1_s[r] : rd0_s[r];
        end
    end

    // Bank FSMs, pointers, output register and overflow next-state.
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_row_d    = wr_row_q;
        rd_col_d    = rd_col_q;
        col_out_d   = col_out_q;
        col_idx_d   = col_idx_q;
        valid_out_d = valid_out_q;
        overflow_d  = overflow_q | (valid_in & ~in_ready_s);

        // The write bank is never FULL and the read bank is always FULL, so they never collide.
        if (wr_en_s) begin
            state_d[wr_bank_q] = (wr_row_q == 3'd7) ? FULL : FILLING;
            wr_bank_d          = (wr_row_q == 3'd7) ? ~wr_bank_q : wr_bank_q;
            wr_row_d           = idx_inc(wr_row_q);
        end else begin
            wr_row_d = wr_row_q;
        end

        if (load_s) begin
            col_out_d   = rdsel_s;
            col_idx_d   = rd_col_q;
            valid_out_d = 1'b1;
            rd_col_d    = idx_inc(rd_col_q);
            if (rd_col_q == 3'd7) begin
                state_d[rd_bank_q] = EMPTY;
                rd_bank_d          = ~rd_bank_q;
            end else begin
                rd_bank_d = rd_bank_q;
            end
        end else if (!valid_out_q || out_ready) begin
            valid_out_d = 1'b0;
        end else begin
            valid_out_d = valid_out_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_row_q    <= 3'd0;
            rd_col_q    <= 3'd0;
            col_idx_q   <= 3'd0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                col_out_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_row_q    <= wr_row_d;
            rd_col_q    <= rd_col_d;
            col_idx_q   <= col_idx_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
            col_out_q   <= col_out_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign col_out   = col_out_q;
    assign col_idx   = col_idx_q;
    assign valid_out = valid_out_q;
    assign last_out  = valid_out_q && (col_idx_q == 3'd7);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: stimulus pushes expected columns, a monitor pops and compares.
module tb_dct_transpose_buf;

    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] row_in [7:0];
    logic          valid_in;
    logic          in_ready;
    logic [DW-1:0] col_out [7:0];
    logic [2:0]    col_idx;
    logic          last_out;
    logic          valid_out;
    logic          out_ready;
    logic          overflow;

    dct_transpose_buf #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .col_out   (col_out),
        .col_idx   (col_idx),
        .last_out  (last_out),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][DW-1:0] d;
        logic [2:0]         idx;
    } beat_t;

    beat_t              exp_q [$];
    logic [7:0][DW-1:0] blk [8];
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 cyc = 0;
    int                 beats = 0;
    int                 first_cyc = -1;
    int                 last_cyc = -1;
    bit                 saw_not_ready = 1'b0;
    bit                 rand_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: stability under stall plus scoreboard pop on every accepted beat.
    initial begin
        logic          stall_p;
        logic [DW-1:0] hold_d [8];
        logic [2:0]    hold_idx;
        beat_t         e;
        stall_p = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_p && !rst) begin
                for (int r = 0; r < 8; r++) chk("stall_col_out", col_out[r], hold_d[r]);
                chk("stall_col_idx", col_idx, hold_idx);
                chk("stall_valid", valid_out, 1);
            end
            stall_p = valid_out && !out_ready && !rst;
            for (int r = 0; r < 8; r++) hold_d[r] = col_out[r];
            hold_idx = col_idx;
            if (valid_out && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("col_idx", col_idx, e.idx);
                    chk("last_out", last_out, (e.idx == 3'd7));
                    for (int r = 0; r < 8; r++) chk("col_out", col_out[r], e.d[r]);
                end
                beats++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    // kind 0: r*8+c+base, 1: alternating extremes, 2: random
    task automatic fill(input int kind, input int base);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (kind)
                    0:       blk[r][c] = DW'(r * 8 + c + base);
                    1:       blk[r][c] = ((r + c) % 2 == 1) ? 18'h1FFFF : 18'h20000;
                    default: blk[r][c] = DW'($urandom);
                endcase
            end
        end
    endtask

    task automatic push_block();
        beat_t e;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) e.d[r] = blk[r][c];
            e.idx = 3'(c);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_row(input int r);
        int t;
        t = 0;
        if (!in_ready) begin
            valid_in      = 1'b0;
            saw_not_ready = 1'b1;
        end
        while (!in_ready && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        for (int c = 0; c < 8; c++) row_in[c] = blk[r][c];
        valid_in = 1'b1;
        @(posedge clk); #1;
        if (r == 7) push_block();
    endtask

    task automatic send_block(input bit stop);
        for (int r = 0; r < 8; r++) send_row(r);
        if (stop) valid_in = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_valid_out"}, valid_out, 0);
        chk({nm, "_col_idx"}, col_idx, 0);
        chk({nm, "_last_out"}, last_out, 0);
        chk({nm, "_overflow"}, overflow, 0);
        chk({nm, "_in_ready"}, in_ready, 1);
        for (int r = 0; r < 8; r++) chk({nm, "_col_out"}, col_out[r], 0);
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        valid_in  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) row_in[c] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single block, latency check
        fill(0, 0);
        send_block(0);
        valid_in = 1'b0;
        chk("t1_no_valid_at_E", valid_out, 0);
        @(posedge clk); #1;
        chk("t1_valid_at_E1", valid_out, 1);
        chk("t1_first_idx", col_idx, 0);
        drain();

        // 2: four blocks back-to-back
        beats = 0; first_cyc = -1; saw_not_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            fill(0, 100 + b * 64);
            send_block(0);
        end
        valid_in = 1'b0;
        drain();
        chk("t2_beats", beats, 32);
        chk("t2_gap_free", last_cyc - first_cyc, 31);
        chk("t2_in_ready_never_low", saw_not_ready, 0);
        chk("t2_overflow", overflow, 0);

        // 3: backpressure, overflow, drain order
        out_ready = 1'b0;
        fill(0, 1000);
        send_block(0);
        fill(0, 2000);
        send_block(0);
        chk("t3_in_ready_low", in_ready, 0);
        for (int c = 0; c < 8; c++) row_in[c] = 18'h3ABCD;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("t3_overflow", overflow, 1);
        chk("t3_stalled_idx", col_idx, 0);
        out_ready = 1'b1;
        t = 0;
        while (t < 20) begin
            @(posedge clk); #1;
            t++;
            if (valid_out && col_idx == 3'd7) break;
            chk("t3_in_ready_held", in_ready, 0);
        end
        chk("t3_col7_seen", t < 20, 1);
        chk("t3_in_ready_back", in_ready, 1);
        drain();
        chk("t3_overflow_sticky", overflow, 1);

        // 4: random out_ready, 20 random blocks
        rand_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    fill(2, 0);
                    send_block(0);
                end
                valid_in  = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // 5: extreme coefficients
        fill(1, 0);
        send_block(1);
        drain();

        // 6a: reset after 3 rows
        fill(0, 3000);
        for (int r = 0; r < 3; r++) send_row(r);
        valid_in = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_outputs("t6a");
        @(posedge clk); #1;
        rst = 1'b0;
        fill(0, 4000);
        send_block(1);
        drain();

        // 6b: reset while draining at column 4
        fill(0, 5000);
        send_block(1);
        t = 0;
        while (!(valid_out && col_idx == 3'd4) && t < 30) begin
            @(posedge clk); #1;
            t++;
        end
        chk("t6b_reached_col4", t < 30, 1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_outputs("t6b");
        @(posedge clk); #1;
        rst = 1'b0;
        fill(2, 0);
        send_block(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
